// File: rtl/tpu_sequencer.sv
// Command sequencer for an N-lane TPU core. It queues matmul commands and, for each one,
// drives the unified-buffer read starts, the systolic weight switch and the VPU pathway.
module tpu_sequencer #(
  parameter int N       = 2,
  parameter int ADDR_W  = 6,
  parameter int PATH_W  = 5,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [ADDR_W-1:0] cmd_w_addr_in,
  input  logic [ADDR_W-1:0] cmd_in_addr_in,
  input  logic [ADDR_W-1:0] cmd_bias_addr_in,
  input  logic [ADDR_W-1:0] cmd_out_addr_in,
  input  logic [ADDR_W-1:0] cmd_rows_in,
  input  logic [PATH_W-1:0] cmd_pathway_in,
  input  logic              cmd_in_transpose_in,
  input  logic              cmd_w_transpose_in,
  input  logic              abort_in,
  input  logic [N-1:0]      vpu_valid_in,
  output logic              ub_rd_weight_start_out,
  output logic [ADDR_W-1:0] ub_rd_weight_addr_out,
  output logic [ADDR_W-1:0] ub_rd_weight_loc_out,
  output logic              ub_rd_weight_transpose_out,
  output logic              sys_switch_out,
  output logic              ub_rd_input_start_out,
  output logic [ADDR_W-1:0] ub_rd_input_addr_out,
  output logic [ADDR_W-1:0] ub_rd_input_loc_out,
  output logic              ub_rd_input_transpose_out,
  output logic              ub_rd_bias_start_out,
  output logic [ADDR_W-1:0] ub_rd_bias_addr_out,
  output logic [ADDR_W-1:0] ub_rd_bias_loc_out,
  output logic [ADDR_W-1:0] ub_wr_addr_out,
  output logic              ub_wr_addr_valid_out,
  output logic [PATH_W-1:0] vpu_data_pathway_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LW_W  = $clog2(N + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_SWITCH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] bias_addr;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W-1:0] rows;
    logic [PATH_W-1:0] pathway;
    logic              in_tr;
    logic              w_tr;
  } cmd_t;

  // ---------------------------------------------------------------- command FIFO
  cmd_t             mem_q [DEPTH];
  cmd_t             cmd_in;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             push, pop;

  state_e           state_q, state_d;

  assign cmd_in = '{w_addr:    cmd_w_addr_in,
                    in_addr:   cmd_in_addr_in,
                    bias_addr: cmd_bias_addr_in,
                    out_addr:  cmd_out_addr_in,
                    rows:      cmd_rows_in,
                    pathway:   cmd_pathway_in,
                    in_tr:     cmd_in_transpose_in,
                    w_tr:      cmd_w_transpose_in};

  assign push = cmd_valid_in && ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    // Registered from the next count so ready is exact in the cycle it is used.
    ready_d = (count_d != CNT_W'(DEPTH));
  end

  // NOTE: storage is not reset; the pointers and count define what is valid,
  // so clearing them is enough to empty the queue and keeps the array reset-free.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // update from the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // ---------------------------------------------------------------- sequencer FSM
  cmd_t              cmd_q, cmd_d;
  logic [LW_W-1:0]   lw_cnt_q, lw_cnt_d;
  logic [ADDR_W-1:0] drain_cnt_q, drain_cnt_d, drain_cnt_nxt;
  logic [TO_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic              err_q, err_d;
  logic              abort_hit;

  assign abort_hit     = abort_in && (state_q != S_IDLE);
  assign drain_cnt_nxt = drain_cnt_q + ADDR_W'(vpu_valid_in[N-1]);

  // NOTE: each always_comb assigns a default to every target first, so no path
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    lw_cnt_d    = lw_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    err_d       = err_q;
    if (abort_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cmd_d    = mem_q[rd_ptr_q];
            lw_cnt_d = '0;
            state_d  = S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (lw_cnt_q == LW_W'(N)) state_d = S_SWITCH;
          else                      lw_cnt_d = lw_cnt_q + 1'b1;
        end
        S_SWITCH: state_d = (cmd_q.rows == '0) ? S_DONE : S_STREAM;
        S_STREAM: begin
          drain_cnt_d = '0;
          cyc_cnt_d   = '0;
          state_d     = S_DRAIN;
        end
        S_DRAIN: begin
          drain_cnt_d = drain_cnt_nxt;
          cyc_cnt_d   = cyc_cnt_q + 1'b1;
          // A completed stream wins over a timeout landing on the same cycle.
          if (drain_cnt_nxt == cmd_q.rows) begin
            state_d = S_DONE;
          end else if (cyc_cnt_d == TO_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      lw_cnt_q    <= '0;
      drain_cnt_q <= '0;
      cyc_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      lw_cnt_q    <= lw_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------- registered outputs
  // Outputs decode the current state and appear one clock later; an abort blanks them.
  logic              w_start_q, w_start_d, switch_q, switch_d;
  logic              in_start_q, in_start_d, bias_start_q, bias_start_d;
  logic              wr_valid_q, wr_valid_d, done_q, done_d, busy_q, busy_d;
  logic              w_tr_q, w_tr_d, in_tr_q, in_tr_d;
  logic [PATH_W-1:0] path_q, path_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d, w_loc_q, w_loc_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d, in_loc_q, in_loc_d;
  logic [ADDR_W-1:0] bias_addr_q, bias_addr_d, bias_loc_q, bias_loc_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  always_comb begin
    w_start_d    = 1'b0;
    switch_d     = 1'b0;
    in_start_d   = 1'b0;
    bias_start_d = 1'b0;
    wr_valid_d   = 1'b0;
    done_d       = 1'b0;
    w_tr_d       = 1'b0;
    in_tr_d      = 1'b0;
    path_d       = '0;
    w_addr_d     = w_addr_q;
    w_loc_d      = w_loc_q;
    in_addr_d    = in_addr_q;
    in_loc_d     = in_loc_q;
    bias_addr_d  = bias_addr_q;
    bias_loc_d   = bias_loc_q;
    wr_addr_d    = wr_addr_q;
    busy_d       = (state_q != S_IDLE) || (count_q != '0);
    if (!abort_hit) begin
      if (state_q inside {S_LOAD_W, S_SWITCH, S_STREAM, S_DRAIN}) begin
        w_tr_d  = cmd_q.w_tr;
        in_tr_d = cmd_q.in_tr;
        path_d  = cmd_q.pathway;
      end
      case (state_q)
        S_LOAD_W: begin
          if (lw_cnt_q == '0) begin
            w_start_d = 1'b1;
            w_addr_d  = cmd_q.w_addr;
            w_loc_d   = ADDR_W'(N);
          end
        end
        S_SWITCH: switch_d = 1'b1;
        S_STREAM: begin
          in_start_d   = 1'b1;
          in_addr_d    = cmd_q.in_addr;
          in_loc_d     = cmd_q.rows;
          bias_start_d = 1'b1;
          bias_addr_d  = cmd_q.bias_addr;
          bias_loc_d   = cmd_q.rows;
          wr_valid_d   = 1'b1;
          wr_addr_d    = cmd_q.out_addr;
        end
        S_DONE:  done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_start_q    <= 1'b0;
      switch_q     <= 1'b0;
      in_start_q   <= 1'b0;
      bias_start_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      w_tr_q       <= 1'b0;
      in_tr_q      <= 1'b0;
      path_q       <= '0;
      w_addr_q     <= '0;
      w_loc_q      <= '0;
      in_addr_q    <= '0;
      in_loc_q     <= '0;
      bias_addr_q  <= '0;
      bias_loc_q   <= '0;
      wr_addr_q    <= '0;
    end else begin
      w_start_q    <= w_start_d;
      switch_q     <= switch_d;
      in_start_q   <= in_start_d;
      bias_start_q <= bias_start_d;
      wr_valid_q   <= wr_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      w_tr_q       <= w_tr_d;
      in_tr_q      <= in_tr_d;
      path_q       <= path_d;
      w_addr_q     <= w_addr_d;
      w_loc_q      <= w_loc_d;
      in_addr_q    <= in_addr_d;
      in_loc_q     <= in_loc_d;
      bias_addr_q  <= bias_addr_d;
      bias_loc_q   <= bias_loc_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  // Only the last lane marks a completed result row; the other lanes are observed elsewhere.
  logic unused_vpu_lanes;
  assign unused_vpu_lanes = ^vpu_valid_in;

  assign cmd_ready_out              = ready_q;
  assign ub_rd_weight_start_out     = w_start_q;
  assign ub_rd_weight_addr_out      = w_addr_q;
  assign ub_rd_weight_loc_out       = w_loc_q;
  assign ub_rd_weight_transpose_out = w_tr_q;
  assign sys_switch_out             = switch_q;
  assign ub_rd_input_start_out      = in_start_q;
  assign ub_rd_input_addr_out       = in_addr_q;
  assign ub_rd_input_loc_out        = in_loc_q;
  assign ub_rd_input_transpose_out  = in_tr_q;
  assign ub_rd_bias_start_out       = bias_start_q;
  assign ub_rd_bias_addr_out        = bias_addr_q;
  assign ub_rd_bias_loc_out         = bias_loc_q;
  assign ub_wr_addr_out             = wr_addr_q;
  assign ub_wr_addr_valid_out       = wr_valid_q;
  assign vpu_data_pathway_out       = path_q;
  assign busy_out                   = busy_q;
  assign done_out                   = done_q;
  assign err_out                    = err_q;

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
Parametrised command sequencer for an N-lane TPU core. It replaces host bit-banging of the unified-buffer read starts, the systolic weight switch and the VPU pathway. It accepts queued matmul commands and issues, per command:
- weight load
- switch pulse
- input and bias stream
- writeback address
It then waits for the VPU result stream to drain before starting the next command. It sits between the host command port and the existing unified_buffer/systolic/vpu control inputs.

Parameters:
N, 2, lane count (systolic rows/cols, VPU lanes)
ADDR_W, 6, UB address and row-count width
PATH_W, 5, VPU pathway select width
DEPTH, 4, command FIFO depth (power of 2, >=2)
TIMEOUT, 255, max DRAIN cycles before error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
cmd_valid_in  in  1  command present
cmd_ready_out  out  1  FIFO not full
cmd_w_addr_in  in  ADDR_W  weight base address
cmd_in_addr_in  in  ADDR_W  input base address
cmd_bias_addr_in  in  ADDR_W  bias base address
cmd_out_addr_in  in  ADDR_W  writeback base address
cmd_rows_in  in  ADDR_W  input rows to stream
cmd_pathway_in  in  PATH_W  VPU pathway for this command
cmd_in_transpose_in  in  1  input read transpose
cmd_w_transpose_in  in  1  weight read transpose
abort_in  in  1  abandon current command
vpu_valid_in  in  N  VPU per-lane output valids
ub_rd_weight_start_out  out  1  weight read start pulse
ub_rd_weight_addr_out  out  ADDR_W  weight address
ub_rd_weight_loc_out  out  ADDR_W  weight rows (=N)
ub_rd_weight_transpose_out  out  1  held weight transpose
sys_switch_out  out  1  shadow-to-active weight pulse
ub_rd_input_start_out  out  1  input read start pulse
ub_rd_input_addr_out  out  ADDR_W  input address
ub_rd_input_loc_out  out  ADDR_W  input rows
ub_rd_input_transpose_out  out  1  held input transpose
ub_rd_bias_start_out  out  1  bias read start pulse
ub_rd_bias_addr_out  out  ADDR_W  bias address
ub_rd_bias_loc_out  out  ADDR_W  bias rows
ub_wr_addr_out  out  ADDR_W  writeback address
ub_wr_addr_valid_out  out  1  writeback address strobe
vpu_data_pathway_out  out  PATH_W  held VPU pathway
busy_out  out  1  state != IDLE or FIFO non-empty
done_out  out  1  command-complete pulse
err_out  out  1  sticky drain timeout

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; state IDLE; counters 0.
  - All outputs 0 except cmd_ready_out=1.
  - Same applies if reset is asserted mid-command: nothing resumes.
- All outputs are registered.
- FIFO:
  - Push on cmd_valid_in && cmd_ready_out.
  - cmd_ready_out = (count != DEPTH).
  - Pop only in IDLE. Push and pop in the same cycle keeps count unchanged.
  - Full FIFO: ready low, inputs ignored.
- States and transitions:
  - IDLE: if FIFO non-empty, pop the head into command registers and go to LOAD_W.
  - LOAD_W: lasts N+1 cycles.
    - First cycle: ub_rd_weight_start_out=1, addr=w_addr, loc=N.
    - Then go to SWITCH.
  - SWITCH: one cycle, sys_switch_out=1.
    - If rows=0, go to DONE.
    - Otherwise go to STREAM.
  - STREAM: one cycle, all pulses in the same cycle:
    - ub_rd_input_start_out=1 (addr=in_addr, loc=rows)
    - ub_rd_bias_start_out=1 (addr=bias_addr, loc=rows)
    - ub_wr_addr_valid_out=1 (ub_wr_addr_out=out_addr)
    - Then go to DRAIN.
  - DRAIN:
    - Count cycles with vpu_valid_in[N-1]=1; at count==rows go to DONE.
    - A cycle counter runs in parallel. Reaching TIMEOUT sets err_out and goes to DONE.
  - DONE: done_out=1 for one cycle, then IDLE.
- Signal holding and timing:
  - Transpose outputs and vpu_data_pathway_out hold the command values from LOAD_W through DRAIN. They are 0 in IDLE/DONE.
  - Address outputs keep their last value. They are only meaningful during their strobe.
  - Latency with idle sequencer and empty FIFO: accept edge → weight start 2 cycles later → switch N+1 after → stream 1 after.
  - vpu_valid_in outside DRAIN is ignored.
- abort_in:
  - In any non-IDLE state: return to IDLE next cycle.
  - No done_out, all pulses 0; FIFO contents retained.
  - Ignored in IDLE.
- err_out is sticky and is cleared only by reset.
- Back-to-back commands: the next pop happens in the first IDLE cycle after DONE, with no extra gap.

Test Plan:
- N=2, one command (w=0, in=8, bias=16, out=24, rows=4, pathway=5'b11000):
  - Weight start 2 cycles after accept, loc=2.
  - Switch 3 cycles later; stream pulse next, with input/bias loc=4 and wr addr=24.
  - 4 valid pulses on vpu_valid_in[1] → done 1 cycle after the 4th; pathway=11000 throughout, 0 after.
- Push 5 commands with none popped: ready drops after 4; 5th ignored; exactly 4 done pulses, in push order.
- rows=0: weight start and switch only; no input/bias/wr strobes; done 1 cycle after switch.
- DRAIN with no VPU valids: after 255 cycles err_out=1 and done pulses; next command still runs; err stays 1.
- abort_in in DRAIN: back to IDLE, no done_out; queued command starts 1 cycle later.
- rst low mid-LOAD_W: all outputs 0 immediately, ready=1, busy=0, FIFO empty after release.
